// File: rtl/grapheme_pxl_fetch.sv
// Frame-buffer reader: walks one FRAME_W x FRAME_H frame as single-word reads and
// streams the returned pixels through a credit-controlled FWFT FIFO with SOF/EOL marks.
module grapheme_pxl_fetch #(
  parameter int MEM_DATA_W = 32,
  parameter int MEM_ADDR_W = 27,
  parameter int FRAME_W    = 1280,
  parameter int FRAME_H    = 720,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] base_addr,
  input  logic                  en,
  input  logic                  clear_flags,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  input  logic                  mem_wait,
  output logic                  mem_rden,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_rd_valid,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  pxl_valid,
  input  logic                  pxl_ready,
  output logic [23:0]           pxl_data,
  output logic                  pxl_sof,
  output logic                  pxl_eol
);

  localparam int NPIX  = FRAME_W * FRAME_H;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int X_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int Y_W   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [X_W-1:0]   LAST_X   = X_W'(FRAME_W - 1);
  localparam logic [Y_W-1:0]   LAST_Y   = Y_W'(FRAME_H - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state;
  logic [MEM_ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]      req_idx;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      out_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [23:0]           fifo_mem [FIFO_DEPTH];
  logic [X_W-1:0]        x_cnt;
  logic [Y_W-1:0]        y_cnt;
  logic                  acc;
  logic                  ret;
  logic                  pop;
  logic                  room_nxt;
  logic                  last_pop;
  logic                  unused_hi;

  assign unused_hi = ^mem_rdata[MEM_DATA_W-1:24];

  // Credit check looks at next-cycle occupancy so a request raised now never overflows.
  always_comb begin
    acc      = mem_rden & ~mem_wait;
    ret      = mem_rd_valid & (outstanding != '0);
    pop      = pxl_valid & pxl_ready;
    out_nxt  = outstanding + CNT_W'(acc) - CNT_W'(ret);
    cnt_nxt  = fifo_count + CNT_W'(ret) - CNT_W'(pop);
    room_nxt = ({1'b0, out_nxt} + {1'b0, cnt_nxt}) < (CNT_W + 1)'(FIFO_DEPTH);
    last_pop = pop & (x_cnt == LAST_X) & (y_cnt == LAST_Y);
  end

  assign busy      = (state != IDLE);
  assign pxl_valid = (fifo_count != '0);
  assign pxl_data  = fifo_mem[rd_ptr];
  assign pxl_sof   = pxl_valid & (x_cnt == '0) & (y_cnt == '0);
  assign pxl_eol   = pxl_valid & (x_cnt == LAST_X);

  always_ff @(posedge clk) begin
    if (ret) fifo_mem[wr_ptr] <= mem_rdata[23:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      req_idx     <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      mem_rden    <= 1'b0;
      mem_addr    <= '0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      fifo_count  <= cnt_nxt;
      done        <= 1'b0;
      if (ret) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (x_cnt == LAST_X) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == LAST_Y) ? '0 : y_cnt + Y_W'(1);
        end else begin
          x_cnt <= x_cnt + X_W'(1);
        end
      end
      // A starvation event in the same cycle as a clear keeps the flag set.
      if (busy & pxl_ready & ~pxl_valid) underrun <= 1'b1;
      else if (clear_flags)              underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            req_idx  <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            state    <= FETCH;
            mem_rden <= en & room_nxt;
            mem_addr <= base_addr;
          end
        end
        FETCH: begin
          if (acc) begin
            req_idx <= req_idx + IDX_W'(1);
            if (req_idx == LAST_IDX) begin
              state    <= DRAIN;
              mem_rden <= 1'b0;
            end else begin
              mem_rden <= en & room_nxt;
              mem_addr <= base_q + MEM_ADDR_W'(req_idx) + MEM_ADDR_W'(1);
            end
          end else if (!mem_rden) begin
            mem_rden <= en & room_nxt;
            mem_addr <= base_q + MEM_ADDR_W'(req_idx);
          end
        end
        DRAIN: begin
          if (last_pop) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
